// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Instruction-fetch / load-store arbiter for a single-port RAM.
// Optional macro ARB_FAIRNESS_EN bounds how long load/store traffic may starve a waiting fetch.
module mem_arbiter #(
   parameter int RAM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [15:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic [15:0] ram_addr,
   output logic        ram_rw,
   output logic [31:0] ram_wdata,
   output logic        ram_wdata_oe,
   input  logic [31:0] ram_rdata,
   output logic        busy
);

   if (RAM_LAT < 1 || RAM_LAT > 15 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
      $error("mem_arbiter: RAM_LAT must be 1..15 and MAX_WAIT 1..255");
   end

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_e;

   localparam logic [3:0] CNT_LOAD = 4'(RAM_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        if_done_q, if_done_d;
   logic        ls_done_q, ls_done_d;
   logic        grant_ls, grant_if;
   logic        fetch_turn;

`ifdef ARB_FAIRNESS_EN
   logic [7:0] wait_q, wait_d;

   assign fetch_turn = if_req && (wait_q == 8'(MAX_WAIT));

   always_comb begin
      wait_d = wait_q;
      if (grant_ls && if_req) begin
         wait_d = wait_q + 8'd1;
      end else if (grant_if) begin
         wait_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q <= 8'd0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign fetch_turn = 1'b0;
`endif

   // Arbitration happens only in IDLE, including the cycle that carries a done pulse.
   always_comb begin
      grant_ls = 1'b0;
      grant_if = 1'b0;
      if (state_q == IDLE) begin
         if (ls_req && !fetch_turn) begin
            grant_ls = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_ls) begin
               state_d = ls_we ? STORE : LOAD;
            end else if (grant_if) begin
               state_d = FETCH;
            end
         end
         default: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Request fields are captured only at the grant, so later input changes cannot disturb an access.
   always_comb begin
      cnt_d       = cnt_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_done_d   = 1'b0;
      ls_done_d   = 1'b0;
      if (grant_ls) begin
         cnt_d      = CNT_LOAD;
         ram_addr_d = ls_addr;
         if (ls_we) begin
            ram_wdata_d = ls_wdata;
         end
      end else if (grant_if) begin
         cnt_d      = CNT_LOAD;
         ram_addr_d = if_addr;
      end else if (state_q != IDLE) begin
         if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            if_done_d = (state_q == FETCH);
            ls_done_d = (state_q != FETCH);
            if (state_q == FETCH) begin
               if_rdata_d = ram_rdata;
            end
            if (state_q == LOAD) begin
               ls_rdata_d = ram_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= 4'd0;
         ram_addr_q  <= 16'd0;
         ram_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         ls_rdata_q  <= 32'd0;
         if_done_q   <= 1'b0;
         ls_done_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_done_q   <= if_done_d;
         ls_done_q   <= ls_done_d;
      end
   end

   always_comb begin
      ram_rw       = (state_q == STORE);
      ram_wdata_oe = (state_q == STORE);
      busy         = (state_q != IDLE);
      ram_addr     = ram_addr_q;
      ram_wdata    = ram_wdata_q;
      if_rdata     = if_rdata_q;
      ls_rdata     = ls_rdata_q;
      if_done      = if_done_q;
      ls_done      = ls_done_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Randomized bench for mem_arbiter, RAM_LAT=1 and RAM_LAT=3 instances vs a transaction model.
// Build with ARB_FAIRNESS_EN defined or not; the model follows the same macro.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int MW = 4;
   localparam int K_NONE = 0, K_FETCH = 1, K_LOAD = 2, K_STORE = 3;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR_EN = 1'b1;
`else
   localparam bit FAIR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst [2];
   logic        if_req [2], ls_req [2], ls_we [2];
   logic [15:0] if_addr [2], ls_addr [2];
   logic [31:0] ls_wdata [2], ram_rdata [2];
   logic        if_done [2], ls_done [2], ram_rw [2], ram_oe [2], busy [2];
   logic [31:0] if_rdata [2], ls_rdata [2], ram_wdata [2];
   logic [15:0] ram_addr [2];

   int          m_kind [2], m_left [2], m_wait [2];
   logic [15:0] m_addr [2];
   logic [31:0] m_wdata [2], m_ifr [2], m_lsr [2];
   logic        m_ifd [2], m_lsd [2];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(.RAM_LAT(g == 0 ? 1 : 3), .MAX_WAIT(MW)) u_dut (
         .clk(clk), .reset(rst[g]),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_done(if_done[g]), .if_rdata(if_rdata[g]),
         .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
         .ls_done(ls_done[g]), .ls_rdata(ls_rdata[g]),
         .ram_addr(ram_addr[g]), .ram_rw(ram_rw[g]), .ram_wdata(ram_wdata[g]),
         .ram_wdata_oe(ram_oe[g]), .ram_rdata(ram_rdata[g]), .busy(busy[g])
      );
   end

   function automatic int lat_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction model: an access occupies the RAM for lat_of(d) cycles, done follows in the next cycle.
   task automatic model_step(int d);
      bit fair_turn;
      if (rst[d]) begin
         m_kind[d] = K_NONE; m_left[d] = 0; m_wait[d] = 0;
         m_addr[d] = '0; m_wdata[d] = '0; m_ifr[d] = '0; m_lsr[d] = '0;
         m_ifd[d] = 1'b0; m_lsd[d] = 1'b0;
      end else begin
         m_ifd[d] = 1'b0;
         m_lsd[d] = 1'b0;
         if (m_kind[d] != K_NONE) begin
            m_left[d]--;
            if (m_left[d] == 0) begin
               if (m_kind[d] == K_FETCH) begin m_ifr[d] = ram_rdata[d]; m_ifd[d] = 1'b1; end
               if (m_kind[d] == K_LOAD) m_lsr[d] = ram_rdata[d];
               if (m_kind[d] != K_FETCH) m_lsd[d] = 1'b1;
               m_kind[d] = K_NONE;
            end
         end else begin
            fair_turn = FAIR_EN && if_req[d] && (m_wait[d] == MW);
            if (ls_req[d] && !fair_turn) begin
               m_kind[d] = ls_we[d] ? K_STORE : K_LOAD;
               m_addr[d] = ls_addr[d];
               if (ls_we[d]) m_wdata[d] = ls_wdata[d];
               if (if_req[d]) m_wait[d]++;
               m_left[d] = lat_of(d);
            end else if (if_req[d]) begin
               m_kind[d] = K_FETCH;
               m_addr[d] = if_addr[d];
               m_wait[d] = 0;
               m_left[d] = lat_of(d);
            end
         end
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) model_step(d);
   end

   task automatic compare_all(int d);
      string p;
      p = $sformatf("d%0d_", d);
      chk({p, "busy"}, 32'(busy[d]), 32'(m_kind[d] != K_NONE));
      chk({p, "ram_rw"}, 32'(ram_rw[d]), 32'(m_kind[d] == K_STORE));
      chk({p, "ram_oe"}, 32'(ram_oe[d]), 32'(m_kind[d] == K_STORE));
      chk({p, "ram_addr"}, 32'(ram_addr[d]), 32'(m_addr[d]));
      chk({p, "if_done"}, 32'(if_done[d]), 32'(m_ifd[d]));
      chk({p, "ls_done"}, 32'(ls_done[d]), 32'(m_lsd[d]));
      chk({p, "if_rdata"}, if_rdata[d], m_ifr[d]);
      chk({p, "ls_rdata"}, ls_rdata[d], m_lsr[d]);
      chk({p, "done_excl"}, 32'(if_done[d] && ls_done[d]), 32'd0);
      if (m_kind[d] == K_STORE) chk({p, "ram_wdata"}, ram_wdata[d], m_wdata[d]);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) compare_all(d);
   endtask

   // Drives one request, scrambles the request fields after the grant and drops req on done.
   task automatic do_req(int d, bit is_ls, bit we, logic [15:0] addr, logic [31:0] data,
                         logic [31:0] rd, output int n);
      bit seen;
      n = 0;
      seen = 1'b0;
      ram_rdata[d] = rd;
      if (is_ls) begin
         ls_req[d] = 1'b1; ls_we[d] = we; ls_addr[d] = addr; ls_wdata[d] = data;
      end else begin
         if_req[d] = 1'b1; if_addr[d] = addr;
      end
      while (!seen && n < 40) begin
         cycle();
         n++;
         seen = is_ls ? ls_done[d] : if_done[d];
         if_addr[d] = 16'($urandom);
         ls_addr[d] = 16'($urandom);
         ls_wdata[d] = $urandom;
      end
      if (is_ls) ls_req[d] = 1'b0; else if_req[d] = 1'b0;
      chk($sformatf("d%0d_req_timeout", d), 32'(seen), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t_ls, t_if, run, n_if, n_ls, pulses;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; if_req[d] = 1'b0; ls_req[d] = 1'b0; ls_we[d] = 1'b0;
         if_addr[d] = '0; ls_addr[d] = '0; ls_wdata[d] = '0; ram_rdata[d] = '0;
         m_kind[d] = K_NONE; m_left[d] = 0; m_wait[d] = 0; m_addr[d] = '0;
         m_wdata[d] = '0; m_ifr[d] = '0; m_lsr[d] = '0; m_ifd[d] = 1'b0; m_lsd[d] = 1'b0;
      end
      repeat (2) cycle();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_wdata", d), ram_wdata[d], 32'd0);
         chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
         rst[d] = 1'b0;
      end

      // Fetch latency and data on both instances, starting right after reset release.
      do_req(0, 1'b0, 1'b0, 16'h0004, 32'd0, 32'h0F00_0000, n);
      chk("fetch_lat_d0", 32'(n), 32'(lat_of(0) + 1));
      chk("fetch_data_d0", if_rdata[0], 32'h0F00_0000);
      do_req(1, 1'b0, 1'b0, 16'h0004, 32'd0, 32'h0F00_0000, n);
      chk("fetch_lat_d1", 32'(n), 32'(lat_of(1) + 1));

      do_req(0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h5555_AAAA, n);
      chk("store_lat_d0", 32'(n), 32'(lat_of(0) + 1));
      chk("store_keeps_ls_rdata", ls_rdata[0], 32'd0);

      // Simultaneous load and fetch: load first, fetch done one access later.
      ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 16'h0020;
      if_req[0] = 1'b1; if_addr[0] = 16'h0040; ram_rdata[0] = 32'h1234_5678;
      t_ls = -1; t_if = -1;
      for (int i = 1; i <= 20 && t_if < 0; i++) begin
         cycle();
         if (ls_done[0] && t_ls < 0) begin t_ls = i; ls_req[0] = 1'b0; end
         if (if_done[0]) begin t_if = i; if_req[0] = 1'b0; end
      end
      if_req[0] = 1'b0; ls_req[0] = 1'b0;
      chk("both_ls_first", 32'(t_ls), 32'(lat_of(0) + 1));
      chk("both_if_gap", 32'(t_if - t_ls), 32'(lat_of(0) + 1));
      chk("both_load_data", ls_rdata[0], 32'h1234_5678);

      // Reset in the second cycle of a RAM_LAT=3 store.
      ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_addr[1] = 16'h0100; ls_wdata[1] = 32'hCAFE_F00D;
      cycle();
      chk("abort_store_rw", 32'(ram_rw[1]), 32'd1);
      cycle();
      rst[1] = 1'b1; ls_req[1] = 1'b0;
      cycle();
      rst[1] = 1'b0;
      chk("abort_rw", 32'(ram_rw[1]), 32'd0);
      chk("abort_busy", 32'(busy[1]), 32'd0);
      chk("abort_addr", 32'(ram_addr[1]), 32'd0);
      pulses = 0;
      repeat (6) begin cycle(); if (ls_done[1]) pulses++; end
      chk("abort_no_done", 32'(pulses), 32'd0);

      // Both requests held continuously for 100 cycles on the RAM_LAT=1 instance.
      rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
      ls_req[0] = 1'b1; ls_we[0] = 1'b0; if_req[0] = 1'b1;
      run = 0; n_if = 0; n_ls = 0;
      repeat (100) begin
         cycle();
         if (ls_done[0]) begin run++; n_ls++; end
         if (if_done[0]) begin chk("fair_run_len", 32'(run), 32'(MW)); run = 0; n_if++; end
      end
      ls_req[0] = 1'b0; if_req[0] = 1'b0;
      chk("held_fetch_count", 32'(n_if), FAIR_EN ? 32'd10 : 32'd0);
      chk("held_ls_count", 32'(n_ls), FAIR_EN ? 32'd40 : 32'd50);
      repeat (4) cycle();

      for (int i = 0; i < 3000; i++) begin
         for (int d = 0; d < 2; d++) begin
            ram_rdata[d] = $urandom;
            rst[d] = ($urandom_range(0, 199) == 0);
            if (if_req[d]) begin
               if (if_done[d] || $urandom_range(0, 31) == 0) if_req[d] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               if_req[d] = 1'b1; if_addr[d] = 16'($urandom);
            end
            if (ls_req[d]) begin
               if (ls_done[d] || $urandom_range(0, 31) == 0) ls_req[d] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               ls_req[d] = 1'b1; ls_we[d] = 1'($urandom);
               ls_addr[d] = 16'($urandom); ls_wdata[d] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) begin
               if_addr[d] = 16'($urandom); ls_addr[d] = 16'($urandom); ls_wdata[d] = $urandom;
            end
         end
         cycle();
      end

      for (int d = 0; d < 2; d++) begin
         if_req[d] = 1'b0; ls_req[d] = 1'b0; rst[d] = 1'b0;
      end
      repeat (6) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
